regfile_param_clr: RTL and testbench

//   Parametrised 2-read/1-write CPU register file with a synchronous write port and per-byte write enables.

---
 rtl/regfile_param_clr_if.sv | 33 +++
 rtl/regfile_param_clr.sv | 118 +++++++++++
 tb/tb_regfile_param_clr.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_clr_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param_clr_if
// Brief    : Read/write/clear bus of the decode-stage register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_param_clr_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  clr;
  logic                  busy;
  logic [ADDR_W-1:0]     ra1;
  logic [ADDR_W-1:0]     ra2;
  logic                  re;
  logic [DATA_W-1:0]     rd1;
  logic [DATA_W-1:0]     rd2;
  logic [ADDR_W-1:0]     wa;
  logic [DATA_W-1:0]     wd;
  logic                  we;
  logic [DATA_W/8-1:0]   wbe;

  modport master (
    output clr, ra1, ra2, re, wa, wd, we, wbe,
    input  busy, rd1, rd2
  );

  modport slave (
    input  clr, ra1, ra2, re, wa, wd, we, wbe,
    output busy, rd1, rd2
  );
endinterface
`default_nettype wire

// File: rtl/regfile_param_clr.sv
`default_nettype none
// ============================================================================
// Module   : regfile_param_clr
// Brief    : 2R/1W register file, byte enables, r0 = 0, optional bypass,
//            sequential clear engine after reset or on clr.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_param_clr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_param_clr_if.slave   bus
);

  localparam int               NREG     = 1 << ADDR_W;
  localparam int               NBYTE    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   rf_q [NREG];

  logic                w_busy;
  logic                w_wr_en;
  logic [DATA_W-1:0]   w_wr_word;
  logic                w_fwd1, w_fwd2;

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] new_w,
    input logic [DATA_W-1:0] old_w,
    input logic [NBYTE-1:0]  be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NBYTE; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // A clr during the sweep only rewinds the pointer; the sweep itself continues.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_CLEAR: begin
        if (bus.clr) begin
          ptr_d = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == PTR_LAST) state_d = S_IDLE;
        end
      end
      default: begin
        if (bus.clr) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  assign w_busy    = (state_q == S_CLEAR);
  assign w_wr_en   = !w_busy && !bus.clr && bus.we && (bus.wa != '0);
  assign w_wr_word = byte_merge(bus.wd, rf_q[bus.wa], bus.wbe);

  // Storage has no reset: the sweep defines every entry before it is readable.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_busy) begin
        rf_q[ptr_q] <= '0;
      end else if (w_wr_en) begin
        rf_q[bus.wa] <= w_wr_word;
      end
    end
  end

  generate
    if (BYPASS) begin : g_bypass
      assign w_fwd1 = bus.we && (bus.wa == bus.ra1);
      assign w_fwd2 = bus.we && (bus.wa == bus.ra2);
    end else begin : g_no_bypass
      assign w_fwd1 = 1'b0;
      assign w_fwd2 = 1'b0;
    end
  endgenerate

  always_comb begin
    bus.rd1 = '0;
    bus.rd2 = '0;
    if (bus.re && !w_busy) begin
      if (bus.ra1 != '0) bus.rd1 = w_fwd1 ? w_wr_word : rf_q[bus.ra1];
      if (bus.ra2 != '0) bus.rd2 = w_fwd2 ? w_wr_word : rf_q[bus.ra2];
    end
  end

  assign bus.busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_param_clr
// Brief    : Randomised bench for regfile_param_clr, BYPASS=1 and BYPASS=0
//            instances driven in lockstep against one behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_param_clr;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr, re, we;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic [3:0]  wbe;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_param_clr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b1 ();
  regfile_param_clr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b0 ();

  assign if_b1.clr = clr;  assign if_b0.clr = clr;
  assign if_b1.re  = re;   assign if_b0.re  = re;
  assign if_b1.we  = we;   assign if_b0.we  = we;
  assign if_b1.ra1 = ra1;  assign if_b0.ra1 = ra1;
  assign if_b1.ra2 = ra2;  assign if_b0.ra2 = ra2;
  assign if_b1.wa  = wa;   assign if_b0.wa  = wa;
  assign if_b1.wd  = wd;   assign if_b0.wd  = wd;
  assign if_b1.wbe = wbe;  assign if_b0.wbe = wbe;

  regfile_param_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) u_dut_b1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b1.slave)
  );

  regfile_param_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_dut_b0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b0.slave)
  );

  // Reference: array contents plus remaining busy edges; the array is wiped
  // as soon as a clear starts since nothing is observable until it ends.
  logic [31:0] mdl [NREG];
  int          clr_left;
  logic        smp_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] nw, input logic [31:0] od,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? nw[8*b +: 8] : od[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] mdl_rd(input logic [4:0] ra, input bit byp);
    if (ra == 0 || !re || clr_left != 0) return 32'h0;
    if (byp && we && wa == ra) return merge(wd, mdl[ra], wbe);
    return mdl[ra];
  endfunction

  task automatic start_clear();
    clr_left = NREG;
    for (int k = 0; k < NREG; k++) mdl[k] = 32'h0;
  endtask

  task automatic step();
    @(negedge clk);
    smp_busy = if_b1.busy;
    check("busy_b1", {31'h0, if_b1.busy}, {31'h0, clr_left != 0});
    check("busy_b0", {31'h0, if_b0.busy}, {31'h0, clr_left != 0});
    check("rd1_b1", if_b1.rd1, mdl_rd(ra1, 1'b1));
    check("rd2_b1", if_b1.rd2, mdl_rd(ra2, 1'b1));
    check("rd1_b0", if_b0.rd1, mdl_rd(ra1, 1'b0));
    check("rd2_b0", if_b0.rd2, mdl_rd(ra2, 1'b0));
    @(posedge clk);
    if (!rst_n)                start_clear();
    else if (clr)              start_clear();
    else if (clr_left != 0)    clr_left--;
    else if (we && wa != 0)    mdl[wa] = merge(wd, mdl[wa], wbe);
    #1;
  endtask

  task automatic idle_in();
    clr = 0; we = 0; re = 1; wa = 0; wd = 0; wbe = 0; ra1 = 0; ra2 = 0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    idle_in();
    we = 1; wa = a; wd = d; wbe = be;
    step();
    we = 0;
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (smp_busy) cnt++;
    end
    check(tag, cnt, 32);
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    @(posedge clk);
    start_clear();
    #1;
    step();
    check("reset_busy", {31'h0, if_b1.busy}, 32'h1);
    check("reset_rd1", if_b1.rd1, 32'h0);

    // Test 1: release reset, 32 busy edges, then every register reads 0
    rst_n = 1;
    for (int i = 0; i < NREG; i++) begin
      ra1 = 5'(i);
      step();
    end
    check("t1_busy_done", {31'h0, if_b1.busy}, 32'h0);
    for (int i = 0; i < NREG; i++) begin
      ra1 = 5'(i); ra2 = 5'(NREG - 1 - i);
      #1 check("t1_zero", if_b1.rd1, 32'h0);
      step();
    end

    // Test 2: full write and read-back; r0 ignores writes
    write(5'd5, 32'hDEADBEEF, 4'hF);
    ra1 = 5'd5;
    #1 check("t2_reg5", if_b0.rd1, 32'hDEADBEEF);
    step();
    write(5'd0, 32'hFFFFFFFF, 4'hF);
    ra1 = 5'd0; ra2 = 5'd0;
    #1 check("t2_reg0", if_b1.rd1, 32'h0);
    step();

    // Test 3: partial byte write
    write(5'd7, 32'h11223344, 4'hF);
    write(5'd7, 32'hAABBCCDD, 4'b0101);
    ra1 = 5'd7;
    #1 check("t3_bytes", if_b0.rd1, 32'h11BB33DD);
    step();

    // Test 4: same-cycle forwarding only in the bypass instance
    write(5'd9, 32'h12345678, 4'hF);
    we = 1; wa = 5'd9; wd = 32'h5A5A5A5A; wbe = 4'hF; ra2 = 5'd9;
    #1 check("t4_byp1", if_b1.rd2, 32'h5A5A5A5A);
    check("t4_byp0", if_b0.rd2, 32'h12345678);
    step();
    idle_in(); ra2 = 5'd9;
    #1 check("t4_after", if_b0.rd2, 32'h5A5A5A5A);
    step();

    // Test 5: clr drops a concurrent write; second clr restarts the sweep
    clr = 1; we = 1; wa = 5'd3; wd = 32'h33333333; wbe = 4'hF;
    step();
    idle_in();
    for (int i = 0; i < 10; i++) step();
    clr = 1;
    step();
    clr = 0;
    count_busy("t5_busy_len");
    for (int i = 0; i < NREG; i++) begin
      ra1 = 5'(i);
      #1 check("t5_zero", if_b1.rd1, 32'h0);
      step();
    end

    // Test 6: re gating, then reset in the middle of a sweep
    write(5'd10, 32'hCAFEF00D, 4'hF);
    write(5'd11, 32'h0BADBEEF, 4'hF);
    re = 0; ra1 = 5'd10; ra2 = 5'd11;
    #1 check("t6_re_rd1", if_b1.rd1, 32'h0);
    check("t6_re_rd2", if_b1.rd2, 32'h0);
    step();
    idle_in();
    clr = 1;
    step();
    clr = 0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 0;
    step();
    rst_n = 1;
    count_busy("t6_rst_sweep");

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      clr   = ($urandom_range(63) == 0);
      rst_n = ($urandom_range(255) != 0);
      re    = ($urandom_range(7) != 0);
      we    = $urandom_range(1);
      wa    = 5'($urandom);
      wd    = $urandom;
      wbe   = 4'($urandom);
      ra1   = ($urandom_range(3) == 0) ? wa : 5'($urandom);
      ra2   = ($urandom_range(3) == 0) ? wa : 5'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
